serial_alu_ctrl: RTL and testbench

Bit-serial ALU sequencer. It accepts a WIDTH-bit operation, then drives a single one-bit ALU slice once per clock, LSB first, chaining the slice's carry through a register. After WIDTH cycles it presents the assembled result and flags. It sits between the instruction-execute control and the one-bit slice, trading latency for area in small cores.

---
 rtl/serial_alu_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_alu_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives a one-bit slice LSB first for WIDTH cycles,
// chaining carry through a register, then presents the assembled result and flags.
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic [WIDTH-2:0] shift_r;

  logic [1:0]       slice_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_s;

  // One-bit ALU slice; returns {carry_out, selected_output}
  function automatic logic [1:0] alu_slice(input logic ai, input logic bi,
                                           input logic ci, input logic [2:0] opc);
    logic bb;
    logic out;
    bb = bi ^ opc[2];
    case (opc[1:0])
      2'b00:   out = ai & bb;
      2'b01:   out = ai | bb;
      default: out = ai ^ bb ^ ci;
    endcase
    return {(ai & bb) | (ai & ci) | (bb & ci), out};
  endfunction

  // Slice evaluation for the current bit and the candidate final result
  always_comb begin
    slice_s   = alu_slice(a_r[cnt_r], b_r[cnt_r], carry_r, op_r);
    shifted_s = {slice_s[0], shift_r};
    last_s    = (cnt_r == LAST);
    if (op_r[1:0] == 2'b11) begin
      // SLT takes the raw MSB sum, without overflow correction
      res_next_s = {{(WIDTH-1){1'b0}}, slice_s[0]};
    end else begin
      res_next_s = shifted_s;
    end
  end

  // Sequencer FSM with registered outputs; results hold until the next DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      carry_r  <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= 3'b000;
      shift_r  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            op_r    <= op;
            cnt_r   <= '0;
            carry_r <= op[2];
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          shift_r <= shifted_s[WIDTH-1:1];
          carry_r <= slice_s[1];
          if (last_s) begin
            state_r  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= res_next_s;
            zero     <= (res_next_s == '0);
            cout     <= op_r[1] & slice_s[1];
            overflow <= op_r[1] & (carry_r ^ slice_s[1]);
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Scoreboard bench for serial_alu_ctrl (WIDTH=8): stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_serial_alu_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       zero;
  logic       cout;
  logic       overflow;

  typedef struct packed {
    logic [7:0] res;
    logic       z;
    logic       c;
    logic       v;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  serial_alu_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .op       (op),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: actual result=%0h required no done pulse", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_outputs {result,zero,cout,overflow}",
              {21'd0, result, zero, cout, overflow}, {21'd0, mon_e});
      end
    end
  end

  // Issue one op, measure done latency and busy window; optional ignored start mid-run
  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic [2:0] iop,
                        input exp_t e, input string name, input bit poke,
                        input logic [7:0] held);
    int  lat;
    int  busy_cyc;
    bit  seen;
    @(negedge clk);
    a = ia; b = ib; op = iop; start = 1'b1;
    exp_q.push_back(e);
    lat = 0; busy_cyc = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && i == 3) begin
        check({name, "_hold_during_run"}, {24'd0, result}, {24'd0, held});
        start = 1'b1; a = 8'hFF; b = 8'h01; op = 3'b010;
      end
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (!seen) begin
      total_cnt++;
      $display("FAIL %s_timeout: actual no done in 20 cycles required done at 9", name);
    end else begin
      check({name, "_latency"}, lat, 9);
      check({name, "_busy_cycles"}, busy_cyc, 8);
    end
  endtask

  initial begin
    int d1;
    int d2;
    reset = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; op = 3'b000;
    repeat (2) @(negedge clk);
    check("reset_outputs {busy,done,result,zero,cout,ovf}",
          {20'd0, busy, done, result, zero, cout, overflow}, {20'd0, 2'b00, 8'h00, 3'b100});
    reset = 1'b0;

    run_op(8'h05, 8'h03, 3'b010, '{8'h08, 1'b0, 1'b0, 1'b0}, "add",     1'b0, 8'h00);
    run_op(8'h42, 8'h42, 3'b110, '{8'h00, 1'b1, 1'b1, 1'b0}, "sub_eq",  1'b0, 8'h00);
    run_op(8'h03, 8'h05, 3'b110, '{8'hFE, 1'b0, 1'b0, 1'b0}, "sub_neg", 1'b0, 8'h00);
    run_op(8'h7F, 8'h01, 3'b010, '{8'h80, 1'b0, 1'b0, 1'b1}, "add_ovf", 1'b0, 8'h00);
    run_op(8'h03, 8'h05, 3'b111, '{8'h01, 1'b0, 1'b0, 1'b0}, "slt_lt",  1'b0, 8'h00);
    run_op(8'h80, 8'h01, 3'b111, '{8'h00, 1'b1, 1'b1, 1'b1}, "slt_unc", 1'b0, 8'h00);
    run_op(8'hF0, 8'h3C, 3'b000, '{8'h30, 1'b0, 1'b0, 1'b0}, "and",     1'b0, 8'h00);
    run_op(8'hF0, 8'h3C, 3'b001, '{8'hFC, 1'b0, 1'b0, 1'b0}, "or",      1'b0, 8'h00);
    run_op(8'hF0, 8'h3C, 3'b100, '{8'hC0, 1'b0, 1'b0, 1'b0}, "andn",    1'b0, 8'h00);
    // Start pulsed mid-run must be dropped; previous result C0 holds meanwhile
    run_op(8'h10, 8'h20, 3'b010, '{8'h30, 1'b0, 1'b0, 1'b0}, "ignore",  1'b1, 8'hC0);
    repeat (12) @(negedge clk);

    // Back-to-back: start held high, second op latched in the DONE cycle
    @(negedge clk);
    a = 8'h01; b = 8'h01; op = 3'b010; start = 1'b1;
    exp_q.push_back('{8'h02, 1'b0, 1'b0, 1'b0});
    d1 = 0; d2 = 0;
    for (int i = 1; i <= 40 && d2 == 0; i++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) begin
          d1 = i;
          a = 8'h0F; b = 8'hF0; op = 3'b001;
          exp_q.push_back('{8'hFF, 1'b0, 1'b0, 1'b0});
        end else begin
          d2 = i;
        end
      end else if (d1 != 0) begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (d2 == 0) begin
      total_cnt++;
      $display("FAIL b2b_timeout: actual first=%0d second=none required 9 and 18", d1);
    end else begin
      check("b2b_first_latency", d1, 9);
      check("b2b_done_interval", d2 - d1, 9);
    end

    // Reset in the 4th RUN cycle aborts the op without a done pulse
    @(negedge clk);
    a = 8'h11; b = 8'h22; op = 3'b010; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midop_reset {busy,done,result,zero,cout,ovf}",
          {20'd0, busy, done, result, zero, cout, overflow}, {20'd0, 2'b00, 8'h00, 3'b100});
    reset = 1'b0;
    run_op(8'h20, 8'h22, 3'b110, '{8'hFE, 1'b0, 1'b0, 1'b0}, "after_reset", 1'b0, 8'h00);

    repeat (12) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
